debounce_multi: RTL and testbench
=================================

Name: debounce_multi

Overview:
- Parametrised N-channel successor to the single-button debouncer; sits between board push-buttons/switches and the game control logic.
- One shared slow-tick prescaler; per channel: 2-FF synchroniser, consecutive-sample stability counter, registered debounced level, one-clk press and release pulses.
- Optional auto-repeat on held buttons for menu and cursor navigation.

Parameters:
- N_CH, 4: number of independent button channels, >=1.
- TICK_DIV, 100000: clk cycles per sample tick, >=2.
- STABLE_TICKS, 3: consecutive ticks a new value must persist before it is accepted, >=1.
- REPEAT_DELAY, 50: ticks held before the first repeat pulse (repeat feature only), >=1.
- REPEAT_RATE, 10: ticks between subsequent repeat pulses (repeat feature only), >=1.

Ports:
- clk  input  1  system clock; all state on posedge.
- rst  input  1  asynchronous reset, active-high.
- btn_in  input  N_CH  raw asynchronous button inputs; 1 = pressed.
- btn_level  output  N_CH  debounced level per channel.
- btn_press  output  N_CH  one-clk pulse on accepted 0->1, plus repeat pulses if enabled.
- btn_release  output  N_CH  one-clk pulse on accepted 1->0.
- sample_tick  output  1  one-clk strobe marking each sample tick, for bench observation.

Behaviour:
- Reset (async assert, sync release): prescaler=0, sample_tick=0, sync FFs=0, all stability and repeat counters=0, btn_level=0, btn_press=0, btn_release=0.
- Prescaler: counts 0..TICK_DIV-1 and wraps to 0. sample_tick is registered high for exactly one clk in the cycle after the count equals TICK_DIV-1, so period = TICK_DIV clk.
- Synchroniser: 2 FFs per channel, clocked every clk and not gated by tick. The filter samples the second stage (s).
- Stability filter, per channel, evaluated only in clk cycles where sample_tick=1:
  - If s == btn_level: cnt <= 0.
  - If s != btn_level and cnt == STABLE_TICKS-1: btn_level <= s, cnt <= 0, and a pulse is raised on btn_press (s=1) or btn_release (s=0).
  - Otherwise: cnt <= cnt+1.
  - cnt width = clog2(STABLE_TICKS)+1. cnt never exceeds STABLE_TICKS-1.
- Pulses: registered, high for exactly the one clk in which btn_level changes; deasserted on every other cycle. btn_press and btn_release are never high together on one channel.
- Latency: the level change occurs on the STABLE_TICKS-th consecutive tick that samples the new value. The input must arrive at s at least 1 clk before the first such tick (2-clk sync delay).
- Glitch rejection: any tick that samples s == btn_level before acceptance clears cnt, so a bounce shorter than STABLE_TICKS ticks produces no output.
- Channels are fully independent. Simultaneous transitions on several channels give simultaneous pulses in the same clk.
- Reset mid-filter or mid-hold discards partial counts. No pulse is emitted on reset assertion or release.

Optional Feature:
- Macro: DEBOUNCE_REPEAT_EN.
- Defined: each channel has a repeat counter, cleared whenever btn_level=0 and at the accepted press.
  - While btn_level=1, the counter increments on each tick.
  - On reaching REPEAT_DELAY: extra btn_press pulse, counter reloads so the next pulse follows REPEAT_RATE ticks later, then every REPEAT_RATE ticks until release.
  - Repeat pulses are one clk wide and coincide with sample_tick+1 timing. btn_release is unaffected.
- Undefined: no repeat logic is instantiated; btn_press pulses only on an accepted 0->1.

Test Plan (N_CH=2, TICK_DIV=4, STABLE_TICKS=3; repeat tests add REPEAT_DELAY=5, REPEAT_RATE=2):
- Reset held 10 clk with btn_in=2'b11 -> all outputs 0 throughout; after release, sample_tick pulses every 4 clk.
- btn_in[0] 0->1, held clean -> btn_level[0]=1 on the 3rd tick sampling 1; btn_press[0] high exactly 1 clk; btn_release=0.
- btn_in[0] high for 2 ticks then low (bounce) -> btn_level[0] stays 0, no pulses; a later 3-tick high is then accepted.
- Release after stable press: btn_in[0] 1->0 for 3 ticks -> btn_level[0]=0, btn_release[0] one clk pulse, btn_press[0]=0.
- Both channels pressed in the same clk -> both btn_press bits pulse in the same cycle. Then rst asserted mid-count on ch1 -> level 0, no pulse, and the filter restarts from cnt=0 after reset.
- DEBOUNCE_REPEAT_EN, ch0 held 20 ticks -> press pulse at acceptance, then at +5 ticks, then every 2 ticks; none after release. Without the macro -> exactly one press pulse.

Source files
------------

// File: rtl/debounce_multi.sv
// N-channel push-button debouncer: shared tick prescaler, per-channel sync + stability filter.
// Define DEBOUNCE_REPEAT_EN to add auto-repeat press pulses on held buttons.
module debounce_multi #(
   parameter int unsigned N_CH         = 4,
   parameter int unsigned TICK_DIV     = 100000,
   parameter int unsigned STABLE_TICKS = 3,
   parameter int unsigned REPEAT_DELAY = 50,
   parameter int unsigned REPEAT_RATE  = 10
) (
   input  logic            clk,
   input  logic            rst,
   input  logic [N_CH-1:0] btn_in,
   output logic [N_CH-1:0] btn_level,
   output logic [N_CH-1:0] btn_press,
   output logic [N_CH-1:0] btn_release,
   output logic            sample_tick
);

   localparam int unsigned PW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
   localparam int unsigned CW = $clog2(STABLE_TICKS) + 1;
   localparam logic [PW-1:0] PRE_LAST = PW'(TICK_DIV - 1);
   localparam logic [CW-1:0] CNT_LAST = CW'(STABLE_TICKS - 1);

   if (N_CH < 1 || TICK_DIV < 2 || STABLE_TICKS < 1 || REPEAT_DELAY < 1 || REPEAT_RATE < 1)
   begin : g_bad_params
      $error("debounce_multi: parameter out of range");
   end

   logic [PW-1:0]   pre_q, pre_d;
   logic            tick_q, tick_d;
   logic [N_CH-1:0] sync1_q, sync1_d, sync2_q, sync2_d;
   logic [N_CH-1:0] level_q, level_d;
   logic [N_CH-1:0] press_q, press_d;
   logic [N_CH-1:0] rel_q, rel_d;
   logic [CW-1:0]   cnt_q [N_CH];
   logic [CW-1:0]   cnt_d [N_CH];

`ifdef DEBOUNCE_REPEAT_EN
   localparam int unsigned RMAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
   localparam int unsigned RW   = $clog2(RMAX + 1);
   localparam logic [RW-1:0] REP_DELAY = RW'(REPEAT_DELAY);
   localparam logic [RW-1:0] REP_RATE  = RW'(REPEAT_RATE);

   logic [RW-1:0]   rep_cnt_q [N_CH];
   logic [RW-1:0]   rep_cnt_d [N_CH];
   // armed: first repeat already issued, subsequent spacing is REPEAT_RATE
   logic [N_CH-1:0] armed_q, armed_d;
   logic [RW-1:0]   rep_nxt;
   logic [RW-1:0]   rep_target;
`endif

   always_comb begin
      pre_d   = (pre_q == PRE_LAST) ? '0 : pre_q + 1'b1;
      tick_d  = (pre_q == PRE_LAST);
      sync1_d = btn_in;
      sync2_d = sync1_q;
   end

   always_comb begin
      level_d = level_q;
      press_d = '0;
      rel_d   = '0;
      cnt_d   = cnt_q;
      for (int i = 0; i < N_CH; i++) begin
         if (tick_q) begin
            if (sync2_q[i] == level_q[i]) begin
               cnt_d[i] = '0;
            end else if (cnt_q[i] == CNT_LAST) begin
               level_d[i] = sync2_q[i];
               press_d[i] = sync2_q[i];
               rel_d[i]   = ~sync2_q[i];
               cnt_d[i]   = '0;
            end else begin
               cnt_d[i] = cnt_q[i] + 1'b1;
            end
         end
      end
`ifdef DEBOUNCE_REPEAT_EN
      rep_cnt_d  = rep_cnt_q;
      armed_d    = armed_q;
      rep_nxt    = '0;
      rep_target = '0;
      for (int i = 0; i < N_CH; i++) begin
         rep_nxt    = rep_cnt_q[i] + 1'b1;
         rep_target = armed_q[i] ? REP_RATE : REP_DELAY;
         // A tick that accepts the release must not also emit a repeat press.
         if (!level_q[i] || rel_d[i]) begin
            rep_cnt_d[i] = '0;
            armed_d[i]   = 1'b0;
         end else if (tick_q) begin
            if (rep_nxt == rep_target) begin
               press_d[i]   = 1'b1;
               rep_cnt_d[i] = '0;
               armed_d[i]   = 1'b1;
            end else begin
               rep_cnt_d[i] = rep_nxt;
            end
         end
      end
`endif
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pre_q   <= '0;
         tick_q  <= 1'b0;
         sync1_q <= '0;
         sync2_q <= '0;
         level_q <= '0;
         press_q <= '0;
         rel_q   <= '0;
         cnt_q   <= '{default: '0};
      end else begin
         pre_q   <= pre_d;
         tick_q  <= tick_d;
         sync1_q <= sync1_d;
         sync2_q <= sync2_d;
         level_q <= level_d;
         press_q <= press_d;
         rel_q   <= rel_d;
         cnt_q   <= cnt_d;
      end
   end

`ifdef DEBOUNCE_REPEAT_EN
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rep_cnt_q <= '{default: '0};
         armed_q   <= '0;
      end else begin
         rep_cnt_q <= rep_cnt_d;
         armed_q   <= armed_d;
      end
   end
`endif

   assign btn_level   = level_q;
   assign btn_press   = press_q;
   assign btn_release = rel_q;
   assign sample_tick = tick_q;

endmodule

// File: tb/tb_debounce_multi.sv
// Self-checking bench for debounce_multi: directed scenarios plus random bouncing inputs,
// every cycle compared against a tick-level behavioural model.
module tb_debounce_multi;

   localparam int unsigned NC = 2;
   localparam int unsigned TD = 4;
   localparam int unsigned ST = 3;
   localparam int unsigned RD = 5;
   localparam int unsigned RR = 2;

   logic          clk = 1'b0;
   logic          rst;
   logic [NC-1:0] btn_in;
   logic [NC-1:0] btn_level, btn_press, btn_release;
   logic          sample_tick;

   debounce_multi #(
      .N_CH(NC), .TICK_DIV(TD), .STABLE_TICKS(ST), .REPEAT_DELAY(RD), .REPEAT_RATE(RR)
   ) dut (
      .clk(clk), .rst(rst), .btn_in(btn_in), .btn_level(btn_level),
      .btn_press(btn_press), .btn_release(btn_release), .sample_tick(sample_tick)
   );

   always #5 clk = ~clk;

   int n_vec = 0;
   int n_err = 0;
   int cyc   = 0;
   int cnt_p [NC];
   int cnt_r [NC];
   int ticks = 0;
   int last_press [NC];

   // Model: m_n edges since reset release; s is btn_in seen two edges ago.
   int unsigned   m_n;
   bit            m_tick;
   bit [NC-1:0]   m_level, m_press, m_rel, m_s;
   int            m_run  [NC];
   int            m_held [NC];
   bit [NC-1:0]   hist [$];

   function automatic void model_reset();
      m_n = 0; m_tick = 0; m_level = '0; m_press = '0; m_rel = '0; m_s = '0;
      for (int c = 0; c < NC; c++) begin m_run[c] = 0; m_held[c] = 0; end
      hist = {};
      hist.push_back('0);
   endfunction

   function automatic void model_edge(bit [NC-1:0] b);
      bit [NC-1:0] nl = m_level;
      bit [NC-1:0] np = '0;
      bit [NC-1:0] nr = '0;
      if (m_tick) begin
         for (int c = 0; c < NC; c++) begin
            if (m_s[c] != m_level[c]) begin
               m_run[c]++;
               if (m_run[c] == ST) begin
                  nl[c] = m_s[c];
                  if (m_s[c]) np[c] = 1'b1; else nr[c] = 1'b1;
                  m_run[c] = 0;
               end
            end else begin
               m_run[c] = 0;
            end
`ifdef DEBOUNCE_REPEAT_EN
            if (m_level[c] && !nr[c]) begin
               m_held[c]++;
               if (m_held[c] == RD || (m_held[c] > RD && (m_held[c] - RD) % RR == 0))
                  np[c] = 1'b1;
            end else begin
               m_held[c] = 0;
            end
`endif
         end
      end
      m_level = nl; m_press = np; m_rel = nr;
      hist.push_back(b);
      m_s = hist.pop_front();
      m_n++;
      m_tick = (m_n % TD == 0);
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
      end
   endtask

   task automatic clear_counts();
      for (int c = 0; c < NC; c++) begin cnt_p[c] = 0; cnt_r[c] = 0; end
      ticks = 0;
   endtask

   // One clock: model follows the edge, outputs compared #1 later, inputs change at negedge.
   task automatic step();
      @(posedge clk);
      if (!rst) model_edge(btn_in);
      cyc++;
      #1;
      check("outputs", 32'({btn_level, btn_press, btn_release, sample_tick}),
            32'({m_level, m_press, m_rel, m_tick}));
      for (int c = 0; c < NC; c++) begin
         cnt_p[c] += int'(btn_press[c]);
         cnt_r[c] += int'(btn_release[c]);
         if (btn_press[c]) last_press[c] = cyc;
      end
      ticks += int'(sample_tick);
      @(negedge clk);
   endtask

   task automatic run(input int n);
      for (int k = 0; k < n; k++) step();
   endtask

   task automatic wait_press(input int c, output bit ok);
      ok = 1'b0;
      for (int k = 0; k < 40 && !ok; k++) begin
         step();
         if (btn_press[c]) ok = 1'b1;
      end
   endtask

   task automatic wait_release(input int c, output bit ok);
      ok = 1'b0;
      for (int k = 0; k < 40 && !ok; k++) begin
         step();
         if (btn_release[c]) ok = 1'b1;
      end
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish, miscompares so far %0d", n_err);
      $fatal(1, "timeout");
   end

   initial begin
      bit ok;
      int exp_rep;
      rst = 1'b1;
      btn_in = 2'b11;
      model_reset();
      #1;
      check("reset_outputs", 32'({btn_level, btn_press, btn_release, sample_tick}), 32'd0);
      @(negedge clk);
      run(10);

      // Reset release: tick period.
      btn_in = 2'b00;
      rst = 1'b0;
      clear_counts();
      run(16);
      check("tick_count_16clk", 32'(ticks), 32'd4);

      // Clean press on ch0.
      clear_counts();
      btn_in[0] = 1'b1;
      run(20);
      check("press0_count", 32'(cnt_p[0]), 32'd1);
      check("press0_no_release", 32'(cnt_r[0]), 32'd0);
      check("press0_level", 32'(btn_level), 32'b01);

      // Release ch0.
      clear_counts();
      btn_in[0] = 1'b0;
      run(20);
      check("release0_count", 32'(cnt_r[0]), 32'd1);
      check("release0_no_press", 32'(cnt_p[0]), 32'd0);
      check("release0_level", 32'(btn_level), 32'b00);

      // Bounce: high for two ticks only.
      clear_counts();
      btn_in[0] = 1'b1;
      run(8);
      btn_in[0] = 1'b0;
      run(20);
      check("bounce_no_press", 32'(cnt_p[0]), 32'd0);
      check("bounce_level", 32'(btn_level[0]), 32'd0);
      btn_in[0] = 1'b1;
      run(20);
      check("after_bounce_press", 32'(cnt_p[0]), 32'd1);
      btn_in[0] = 1'b0;
      run(20);

      // Simultaneous press on both channels.
      clear_counts();
      btn_in = 2'b11;
      run(20);
      check("both_press0", 32'(cnt_p[0]), 32'd1);
      check("both_press1", 32'(cnt_p[1]), 32'd1);
      check("both_same_cycle", 32'(last_press[0]), 32'(last_press[1]));
      btn_in = 2'b00;
      run(20);

      // Reset mid-count on ch1.
      clear_counts();
      btn_in = 2'b10;
      run(6);
      rst = 1'b1;
      model_reset();
      #1;
      check("midreset_outputs", 32'({btn_level, btn_press, btn_release}), 32'd0);
      run(2);
      rst = 1'b0;
      run(8);
      check("midreset_not_yet", 32'(btn_level[1]), 32'd0);
      run(12);
      check("midreset_accept", 32'(btn_level[1]), 32'd1);
      check("midreset_press_once", 32'(cnt_p[1]), 32'd1);
      check("midreset_no_release", 32'(cnt_r[1]), 32'd0);
      btn_in = 2'b00;
      run(20);

      // Long hold on ch0: repeat pulses only with the repeat build.
      btn_in[0] = 1'b1;
      wait_press(0, ok);
      check("hold_accept_seen", 32'(ok), 32'd1);
      clear_counts();
      run(15 * TD);
`ifdef DEBOUNCE_REPEAT_EN
      exp_rep = 6;
`else
      exp_rep = 0;
`endif
      check("hold_repeat_count", 32'(cnt_p[0]), 32'(exp_rep));
      btn_in[0] = 1'b0;
      wait_release(0, ok);
      check("hold_release_seen", 32'(ok), 32'd1);
      clear_counts();
      run(40);
      check("no_press_after_release", 32'(cnt_p[0]), 32'd0);

      // Random bouncing on both channels.
      for (int k = 0; k < 400; k++) begin
         for (int c = 0; c < NC; c++)
            if ($urandom_range(0, 5) == 0) btn_in[c] = ~btn_in[c];
         step();
      end
      btn_in = 2'b11;
      run(120);
      btn_in = 2'b00;
      run(30);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
